// File: rtl/seg_mux_pkg.sv
// Shared constants and hex segment table for the seven-segment display mux.
package seg_mux_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Defaults sized for the 100 MHz board clock: 1 ms per digit, 20 us dead time.
    localparam int DEF_REFRESH_DIV = 100000;
    localparam int DEF_DEAD_CYCLES = 2000;

    // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg_hex_decode
    import seg_mux_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed seven-segment driver with per-frame input snapshot, dead time
// and PWM brightness. Define SEG_LZ_SUPPRESS_EN to blank leading zero digits.
module seg_display_mux
    import seg_mux_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
    parameter int BRIGHT_W    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   data,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic [BRIGHT_W-1:0]       brightness,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                sseg,
    output logic                      dp
);

    localparam int CNT_W = $clog2(REFRESH_DIV + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_C    = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] DIG_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [63:0]      LIT_SPAN  = 64'(REFRESH_DIV - DEAD_CYCLES);
    localparam logic [CNT_W-1:0] ON_LEN_RST = CNT_W'(LIT_SPAN >> BRIGHT_W);

    logic [CNT_W-1:0]        slot_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic                    first_snap;
    logic [4*NUM_DIGITS-1:0] data_s;
    logic [NUM_DIGITS-1:0]   dp_s;
    logic [NUM_DIGITS-1:0]   blank_s;
    logic [CNT_W-1:0]        on_len;

    logic                    wrap, snap, lit;
    logic [63:0]             on_prod;
    logic [CNT_W-1:0]        on_len_nx;
    logic [NUM_DIGITS-1:0]   blank_nx;
    logic [NUM_DIGITS-1:0]   an_nx;
    logic [3:0]              nib;
    logic [6:0]              seg_dec;

    assign wrap = (slot_cnt == SLOT_LAST);
    assign snap = first_snap || (wrap && digit_idx == DIG_LAST);

    // Full-width product so large REFRESH_DIV never truncates before the shift.
    assign on_prod   = LIT_SPAN * (64'(brightness) + 64'd1);
    assign on_len_nx = CNT_W'(on_prod >> BRIGHT_W);

    always_comb begin
        blank_nx = blank;
`ifdef SEG_LZ_SUPPRESS_EN
        begin : lz
            logic stop;
            stop = 1'b0;
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                if (!stop) begin
                    if (data[4*i +: 4] == 4'h0 && !dp_in[i]) blank_nx[i] = 1'b1;
                    else                                      stop        = 1'b1;
                end
            end
        end
`endif
    end

    // Subtract instead of adding so DEAD_C + on_len cannot overflow CNT_W.
    assign lit = (slot_cnt >= DEAD_C) && ((slot_cnt - DEAD_C) < on_len) && !blank_s[digit_idx];
    assign nib = data_s[{digit_idx, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .nib (nib),
        .seg (seg_dec)
    );

    always_comb begin
        an_nx = '1;
        if (lit) an_nx[digit_idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt   <= '0;
            digit_idx  <= '0;
            first_snap <= 1'b1;
            data_s     <= '0;
            dp_s       <= '0;
            blank_s    <= '1;
            on_len     <= ON_LEN_RST;
            an         <= '1;
            sseg       <= SEG_BLANK;
            dp         <= 1'b1;
        end else begin
            first_snap <= 1'b0;
            if (wrap) begin
                slot_cnt  <= '0;
                digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
                slot_cnt  <= slot_cnt + 1'b1;
            end
            if (snap) begin
                data_s  <= data;
                dp_s    <= dp_in;
                blank_s <= blank_nx;
                on_len  <= on_len_nx;
            end
            an   <= an_nx;
            sseg <= lit ? seg_dec : SEG_BLANK;
            dp   <= lit ? ~dp_s[digit_idx] : 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Randomised self-checking bench for seg_display_mux against a cycle-count model.
module tb_seg_display_mux;

    localparam int ND = 4, RD = 8, DEAD = 1, BW = 2;
    localparam int FRAME = ND * RD;

    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   data;
    logic [3:0]    dp_in, blank;
    logic [BW-1:0] brightness;
    logic [3:0]    an;
    logic [6:0]    sseg;
    logic          dp;

    int checks = 0, errors = 0;
    bit mdl_on = 1'b0;

    seg_display_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DEAD), .BRIGHT_W(BW)) dut (
        .clk(clk), .reset(reset), .data(data), .dp_in(dp_in), .blank(blank),
        .brightness(brightness), .an(an), .sseg(sseg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {an,sseg,dp} after the n-th clock edge since release (n from 0).
    function automatic logic [11:0] model_out(int n, logic [15:0] d, logic [3:0] dpv,
                                              logic [3:0] bl, int on);
        int ph = n % RD;
        int dg = (n / RD) % ND;
        logic [3:0] a = 4'hF;
        if (ph >= DEAD && ph < DEAD + on && !bl[dg]) begin
            a[dg] = 1'b0;
            return {a, HEX[d[dg*4 +: 4]], ~dpv[dg]};
        end
        return {4'hF, 7'h7F, 1'b1};
    endfunction

    function automatic logic [3:0] model_blank(logic [15:0] d, logic [3:0] dpv, logic [3:0] bl);
        logic [3:0] r = bl;
`ifdef SEG_LZ_SUPPRESS_EN
        for (int i = 3; i >= 1; i--) begin
            if (d[i*4 +: 4] != 4'h0 || dpv[i]) break;
            r[i] = 1'b1;
        end
`endif
        return r;
    endfunction

    int          n;
    logic [15:0] sh_data;
    logic [3:0]  sh_dp, sh_blank;
    int          sh_on;
    logic [11:0] exp_out;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n        <= 0;
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_blank <= '1;
            sh_on    <= 0;
            exp_out  <= {4'hF, 7'h7F, 1'b1};
        end else begin
            exp_out <= model_out(n, sh_data, sh_dp, sh_blank, sh_on);
            n       <= n + 1;
            if (n == 0 || n % FRAME == FRAME - 1) begin
                sh_data  <= data;
                sh_dp    <= dp_in;
                sh_blank <= model_blank(data, dp_in, blank);
                sh_on    <= ((RD - DEAD) * (int'(brightness) + 1)) >> BW;
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("an", 32'(an), 32'(exp_out[11:8]));
            chk("sseg", 32'(sseg), 32'(exp_out[7:1]));
            chk("dp", 32'(dp), 32'(exp_out[0]));
            chk("one_anode", 32'($countones(~an) <= 1), 32'd1);
        end
    end

    int         lit_per [4];
    logic [6:0] seen_seg [4];

    task automatic window(input int cycles);
        for (int d = 0; d < 4; d++) begin lit_per[d] = 0; seen_seg[d] = 7'h7F; end
        repeat (cycles) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) if (!an[d]) begin lit_per[d]++; seen_seg[d] = sseg; end
        end
    endtask

    task automatic wait_an(input logic [3:0] pat, input string tag);
        int k = 0;
        while (an !== pat && k < 200) begin @(negedge clk); k++; end
        chk(tag, 32'(an), 32'(pat));
    endtask

    task automatic set_in(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                          input logic [BW-1:0] br);
        data = d; dp_in = p; blank = b; brightness = br;
    endtask

    int tot;

    initial begin
        reset = 1'b0;
        set_in(16'h0000, 4'b0000, 4'b0000, 2'd3);
        repeat (4) @(negedge clk);
        mdl_on = 1'b1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_sseg", 32'(sseg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);

        reset = 1'b1;
        @(negedge clk);
        chk("first_dark", 32'(an), 32'hF);
        wait_an(4'b1110, "d0_first");
        chk("d0_zero_seg", 32'(sseg), 32'h40);

        set_in(16'h12AF, 4'b0000, 4'b0000, 2'd3);
        repeat (2 * FRAME) @(negedge clk);
        window(FRAME);
        tot = lit_per[0] + lit_per[1] + lit_per[2] + lit_per[3];
        chk("b3_lit", 32'(tot), 32'd28);
        chk("seg_d0", 32'(seen_seg[0]), 32'h0E);
        chk("seg_d1", 32'(seen_seg[1]), 32'h08);
        chk("seg_d2", 32'(seen_seg[2]), 32'h24);
        chk("seg_d3", 32'(seen_seg[3]), 32'h79);

        brightness = 2'd0;
        repeat (2 * FRAME) @(negedge clk);
        window(FRAME);
        chk("b0_lit", 32'(lit_per[0] + lit_per[1] + lit_per[2] + lit_per[3]), 32'd4);

        brightness = 2'd1;
        repeat (2 * FRAME) @(negedge clk);
        window(FRAME);
        chk("b1_lit", 32'(lit_per[0] + lit_per[1] + lit_per[2] + lit_per[3]), 32'd12);

        set_in(16'h1111, 4'b0000, 4'b0000, 2'd3);
        repeat (2 * FRAME) @(negedge clk);
        wait_an(4'b1101, "mid_d1");
        data = 16'h2222;
        wait_an(4'b1011, "mid_d2");
        chk("mid_d2_old", 32'(sseg), 32'h79);
        wait_an(4'b0111, "mid_d3");
        chk("mid_d3_old", 32'(sseg), 32'h79);
        wait_an(4'b1110, "next_d0");
        chk("next_d0_new", 32'(sseg), 32'h24);

        set_in(16'h0050, 4'b0000, 4'b0000, 2'd3);
        repeat (2 * FRAME) @(negedge clk);
        window(FRAME);
`ifdef SEG_LZ_SUPPRESS_EN
        chk("lz_d3_dark", 32'(lit_per[3]), 32'd0);
        chk("lz_d2_dark", 32'(lit_per[2]), 32'd0);
        chk("lz_d1", 32'(seen_seg[1]), 32'h12);
        chk("lz_d0", 32'(seen_seg[0]), 32'h40);
        dp_in = 4'b0100;
        repeat (2 * FRAME) @(negedge clk);
        wait_an(4'b1011, "lz_dp_d2");
        chk("lz_dp_seg", 32'(sseg), 32'h40);
        chk("lz_dp_dp", 32'(dp), 32'd0);
`else
        chk("zero_d3", 32'(seen_seg[3]), 32'h40);
        chk("zero_d2", 32'(seen_seg[2]), 32'h40);
        chk("zero_d1", 32'(seen_seg[1]), 32'h12);
        chk("zero_lit3", 32'(lit_per[3]), 32'd7);
`endif

        for (int it = 0; it < 40; it++) begin
            set_in(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)),
                   BW'($urandom));
            repeat ($urandom_range(1, 45)) @(negedge clk);
        end

        set_in(16'h4321, 4'b0000, 4'b0000, 2'd3);
        repeat (2 * FRAME) @(negedge clk);
        wait_an(4'b1011, "pre_rst_d2");
        #2 reset = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'hF);
        chk("async_sseg", 32'(sseg), 32'h7F);
        chk("async_dp", 32'(dp), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        begin
            int k = 0;
            while (an === 4'hF && k < 100) begin @(negedge clk); k++; end
            chk("restart_d0", 32'(an), 32'hE);
            chk("restart_seg", 32'(sseg), 32'h79);
        end
        repeat (2 * FRAME) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Parametrised time-multiplexed seven-segment display driver for NUM_DIGITS common-anode digits. It takes packed hex nibbles, per-digit decimal points and blank masks, plus a brightness code, and scans the digits from an internal refresh prescaler. Per-digit anode dead time suppresses ghosting. Inputs are snapshotted once per frame so the display never tears. It sits between switch/counter logic and the board's `an`/`sseg`/`dp` pins, and replaces the separate clock-divider + 4-digit mux pair.

## Interface
- NUM_DIGITS, 4, digits scanned (2..8)
- REFRESH_DIV, 100000, clk cycles per digit slot (≥ DEAD_CYCLES+2)
- DEAD_CYCLES, 2000, cycles at start of each slot with all anodes off
- BRIGHT_W, 4, brightness code width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- data  in  4*NUM_DIGITS  hex nibble per digit; digit i = data[4i+3:4i], digit 0 rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high
- blank  in  NUM_DIGITS  force digit dark, active-high
- brightness  in  BRIGHT_W  on-time code; 0 = minimum, all-ones = full
- an  out  NUM_DIGITS  anode enables, active-low
- sseg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

## Operation
- slot_cnt counts 0..REFRESH_DIV-1 and wraps. digit_idx advances 0→NUM_DIGITS-1 on each wrap, then back to 0.
- Frame snapshot: when slot_cnt==REFRESH_DIV-1 and digit_idx==NUM_DIGITS-1, data/dp_in/blank/brightness are captured into shadow registers. A snapshot is also taken on the first clk edge after reset deasserts.
- on_len = ((REFRESH_DIV-DEAD_CYCLES)*(brightness_s+1)) >> BRIGHT_W. It is computed at snapshot with full-width product and no truncation before the shift.
- Digit lit iff DEAD_CYCLES ≤ slot_cnt < DEAD_CYCLES+on_len and the shadow blank bit is clear (after suppression).
- When lit: an has only bit digit_idx low; sseg = hex decode of the shadow nibble; dp = ~dp_s[digit_idx].
- When dark: an all ones, sseg 7'h7F, dp 1.
- Changes to inputs mid-frame have no effect until the next snapshot.

## Timing
- Reset (reset==0, asynchronous):
  - an all ones, sseg 7'h7F, dp 1.
  - slot_cnt 0, digit_idx 0.
  - Shadow blank all ones, shadow data 0, shadow brightness 0.
- an/sseg/dp are registered: they reflect slot_cnt/digit_idx of the previous cycle (1-cycle latency).
- The first snapshot lands 1 cycle after reset release. Digit 0 first lights at slot_cnt==DEAD_CYCLES, with outputs visible one cycle later.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles.
- Snapshot and digit wrap happen on the same edge. The new frame's digit 0 uses the new shadow values.
- Reset asserted mid-slot forces dark outputs immediately (asynchronously) and restarts from digit 0.
- Dead time always precedes an anode change, so two anodes are never low in the same cycle.

## Configuration
- SEG_LZ_SUPPRESS_EN defined:
  - At snapshot, leading digits (from NUM_DIGITS-1 downward) with nibble 0 and dp_in 0 have their shadow blank bit set.
  - Suppression stops at the first nonzero nibble or set dp.
  - Digit 0 is never suppressed.
- Undefined: zeros are displayed; only the blank input darkens digits.

## Structure
- Package seg_mux_pkg holds:
  - SEG_BLANK = 7'h7F.
  - The 16-entry active-low hex segment table as a function.
  - The default REFRESH_DIV/DEAD_CYCLES constants for the 100 MHz board clock.
- One sub-module: seg_hex_decode (4-bit nibble → 7-bit active-low segments, combinational), instanced once on the muxed shadow nibble.
- Counters, snapshot, PWM compare and suppression stay in seg_display_mux.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=1, BRIGHT_W=2.
- Reset hold, then release → outputs dark until first slot. Digit 0 lights with sseg 7'h40 for data=16'h0000 (macro off). an sequence 1110,1101,1011,0111 repeats every 32 cycles.
- data=16'h12AF, brightness=3 → per slot: 1 dark cycle then 7 lit cycles. sseg 7'h0E, 7'h08, 7'h24, 7'h79 on digits 0..3. Never two anodes low at once.
- brightness=0 → 1 lit cycle per slot (on_len=7*1>>2=1). brightness=1 → 3 lit cycles.
- data changed from 16'h1111 to 16'h2222 while digit 1 is lit → digits 2,3 still show 1. All digits show 2 from the next frame.
- SEG_LZ_SUPPRESS_EN, data=16'h0050, dp_in=4'b0000 → digits 3,2 dark, digits 1,0 show 5,0. With dp_in=4'b0100, digit 2 shows 0 with dp=0.
- reset asserted mid-slot of digit 2 → an all ones in the same cycle. After release the scan restarts at digit 0.
